// File: rtl/bcd_score_accumulator.sv
// Packed-BCD running score register. Operands arrive over valid/ready and are folded into
// the score one digit per cycle, LSD first, through a single BCD digit adder with carry.
//
// state | meaning
// IDLE  | waiting for an operand; add_ready high unless clear is asserted
// ADD   | adding digit idx of the latched operand into the score, busy high
module bcd_score_accumulator #(
  parameter int DIGITS     = 6,
  parameter int ADD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    add_valid,
  input  logic [4*ADD_DIGITS-1:0] add_value,
  output logic                    add_ready,
  output logic [4*DIGITS-1:0]     score,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    bcd_err
);

  localparam int                  IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic {IDLE, ADD} state_t;

  state_t                state, state_next;
  logic [IDX_W-1:0]      idx;
  logic                  carry;
  logic [4*DIGITS-1:0]   op;
  logic                  accept;
  logic                  operand_bad;
  logic                  last_digit;
  logic [3:0]            cur_digit;
  logic [3:0]            op_digit;
  logic [4:0]            sum_raw;
  logic [3:0]            sum_digit;
  logic                  carry_out;
  logic [4*DIGITS-1:0]   score_wr;

  assign add_ready  = (state == IDLE) & ~clear;
  assign accept     = add_valid & add_ready;
  assign busy       = (state == ADD);
  assign last_digit = (idx == LAST_IDX);

  always_comb begin
    operand_bad = 1'b0;
    for (int i = 0; i < ADD_DIGITS; i++) begin
      if (add_value[4*i +: 4] > 4'd9) operand_bad = 1'b1;
    end
  end

  // Operand is stored zero-extended to score width so upper digits add as 0.
  always_comb begin
    cur_digit = 4'd0;
    op_digit  = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = score[4*i +: 4];
        op_digit  = op[4*i +: 4];
      end
    end
  end

  always_comb begin
    sum_raw = {1'b0, cur_digit} + {1'b0, op_digit} + {4'd0, carry};
    if (sum_raw > 5'd9) begin
      sum_digit = sum_raw[3:0] + 4'd6;
      carry_out = 1'b1;
    end else begin
      sum_digit = sum_raw[3:0];
      carry_out = 1'b0;
    end
  end

  always_comb begin
    score_wr = score;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) score_wr[4*i +: 4] = sum_digit;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !operand_bad) state_next = ADD;
      ADD:     if (last_digit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score    <= '0;
      op       <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      bcd_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      bcd_err <= 1'b0;
      if (clear) begin
        score    <= '0;
        overflow <= 1'b0;
        idx      <= '0;
        carry    <= 1'b0;
      end else if (state == IDLE) begin
        if (accept) begin
          if (operand_bad) begin
            bcd_err <= 1'b1;
          end else begin
            op    <= (4*DIGITS)'(add_value);
            idx   <= '0;
            carry <= 1'b0;
          end
        end
      end else if (last_digit) begin
        done  <= 1'b1;
        idx   <= '0;
        carry <= 1'b0;
        // Carry out of the top digit saturates instead of wrapping.
        if (carry_out) begin
          score    <= ALL_NINES;
          overflow <= 1'b1;
        end else begin
          score <= score_wr;
        end
      end else begin
        score <= score_wr;
        idx   <= idx + 1'b1;
        carry <= carry_out;
      end
    end
  end

endmodule
